keycode_dispatcher: RTL and testbench
=====================================

Name: keycode_dispatcher

Overview:
- Producer side of the per-player `Keycode` input.
- Takes the raw 6-slot USB HID keyboard report written by the NIOS. Splits it into one movement keycode per player (P1: W/A/S/D, P2: arrow keys).
- Converts held keys into frame-aligned step keycodes with press/auto-repeat timing, so each player module sees one keycode per frame and 8'h00 otherwise.
- Sits between the keyboard report registers and the two player instances.

Parameters:
- RepeatDelay, 12: frames between the initial step and the first repeat step (1..255).
- RepeatRate, 6: frames between subsequent repeat steps (1..255).
- StaleFrames, 60: frames without a new report before the report is treated as all-zero (1..255).

Ports:
- Clk  in  1  system clock; all logic is synchronous to it.
- ResetN  in  1  asynchronous active-low reset.
- KeyReport  in  48  six keycodes; slot 0 = [7:0] … slot 5 = [47:40].
- ReportValid  in  1  one-cycle pulse: KeyReport is new this cycle.
- FrameTick  in  1  one-cycle pulse per video frame (vsync edge); the only instant outputs change.
- P1Keycode  out  8  step keycode for player one, held for one frame period.
- P2Keycode  out  8  step keycode for player two, held for one frame period.
- P1Held  out  1  a P1 movement key is currently held (latched report).
- P2Held  out  1  a P2 movement key is currently held (latched report).

Behaviour:

Reset (asynchronous, ResetN=0):
- All outputs are 0.
- Latched report = 0, stale counter = 0, both repeat FSMs in IDLE.

Report capture:
- On ReportValid, KeyReport is latched and the stale counter clears.
- On each FrameTick without a ReportValid in the same cycle, the stale counter increments, saturating at StaleFrames.
- Counter == StaleFrames forces the decoded report to all-zero.
- ReportValid and FrameTick in the same cycle: the new report is used for that tick.

Decode (combinational from the effective report):
- P1 set: 1A, 04, 16, 07. P2 set: 52, 50, 51, 4F.
- Each player's held key H = the matching keycode in the lowest-numbered slot, else 8'h00.
- Keys outside both sets are ignored. A key in the P1 set never affects P2, and vice versa.

Per-player repeat FSM (advances only on FrameTick; counter 8 bits):
- IDLE:
  - H≠0 → output H, cnt=0, remember key K=H, go DELAY.
  - Otherwise output 0.
- DELAY:
  - H==0 → output 0, go IDLE.
  - H≠K → treated as a new press: output H, cnt=0, K=H, stay DELAY.
  - Otherwise cnt++. If the new cnt == RepeatDelay, output K, cnt=0, go REPEAT; else output 0.
- REPEAT:
  - H==0 → IDLE (output 0). H≠K → same as a new press (go DELAY).
  - Otherwise cnt++. If the new cnt == RepeatRate, output K and cnt=0; else output 0.
- Resulting step frames for a steady hold: 0, RepeatDelay, RepeatDelay+RepeatRate, …

Output timing:
- Outputs are registered and update only in the FrameTick cycle.
- They are held until the next FrameTick.
- Latency from FrameTick to output is 1 clock.
- PxHeld = (H≠0), registered on FrameTick.

Mid-operation reset:
- ResetN low between ticks clears outputs immediately.
- The first tick after release behaves as IDLE.

Decomposition:
- Package crossy_keys_pkg:
  - P1/P2 keycode constants (KEY_W, KEY_A, KEY_S, KEY_D, KEY_UP, KEY_LEFT, KEY_DOWN, KEY_RIGHT).
  - Repeat-state enum (IDLE, DELAY, REPEAT).
- Sub-module key_repeater: one FSM plus counter, inputs H and FrameTick, output step keycode. Instantiated twice.
- Report latch, stale counter and slot-priority decode stay in the top module.

Test Plan:
- Reset: ResetN=0 mid-frame → P1Keycode=P2Keycode=00, PxHeld=0 immediately.
- Hold W: report slot0=1A held 30 frames, RepeatDelay=12, RepeatRate=6 → P1Keycode=1A on frames 0, 12, 18, 24, 00 elsewhere; P2Keycode=00 throughout.
- Simultaneous players: slot0=04, slot1=50 → P1=04 and P2=50 on the same tick; slot0=1A, slot1=04 → P1=1A (slot priority).
- Direction change: hold 07 for 5 frames, then switch to 16 → 16 emitted on the switch frame, then next at switch+12.
- Stale: one ReportValid with 1A, then no more reports for 60 frames → steps continue until the stale counter saturates; on the 60th tick without a report, P1Held=0 and output 00.
- Same-cycle events: ReportValid (1A→00) coincident with FrameTick → that tick outputs 00 and the FSM goes IDLE.

Source files
------------

// File: rtl/crossy_keys_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : crossy_keys_pkg
//  Purpose  : Shared keycode constants, repeat-FSM state encoding and
//             keycode classification helpers for the keyboard dispatch path.
//  Contents : KEY_* movement keycodes (HID usage IDs), NUM_SLOTS, SLOT_W,
//             rpt_state_t, is_p1_key(), is_p2_key()
//  Revision : 1.0 - initial release
// ============================================================================
package crossy_keys_pkg;

  // Player one movement keys (W/A/S/D)
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;

  // Player two movement keys (arrows)
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  // HID boot report carries six keycode slots of one byte each
  localparam int NUM_SLOTS = 6;
  localparam int SLOT_W    = 8;

  // Per-player press / auto-repeat state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  function automatic logic is_p1_key(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
  endfunction

  function automatic logic is_p2_key(input logic [7:0] k);
    return (k == KEY_UP) || (k == KEY_LEFT) || (k == KEY_DOWN) || (k == KEY_RIGHT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_repeater.sv
`default_nettype none
// ============================================================================
//  Module   : key_repeater
//  Purpose  : Turns a held movement keycode into frame-aligned step keycodes:
//             one step on press, another after REPEAT_DELAY frames, then one
//             every REPEAT_RATE frames while the same key stays held.
//  Ports    : clk          - system clock
//             rst_n        - asynchronous active-low reset
//             i_frame_tick - one-cycle pulse per video frame
//             i_held_key   - currently held movement keycode (8'h00 = none)
//             o_step_key   - step keycode, held for one frame period
//  Revision : 1.0 - initial release
// ============================================================================
module key_repeater
  import crossy_keys_pkg::*;
#(
  parameter int REPEAT_DELAY = 12,
  parameter int REPEAT_RATE  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic [7:0] i_held_key,
  output logic [7:0] o_step_key
);

  localparam logic [7:0] C_DELAY = 8'(REPEAT_DELAY);
  localparam logic [7:0] C_RATE  = 8'(REPEAT_RATE);

  rpt_state_t r_state;
  rpt_state_t w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic [7:0] r_key;
  logic [7:0] w_key_next;
  logic [7:0] r_step;
  logic [7:0] w_step_next;
  logic [7:0] w_cnt_inc;

  assign w_cnt_inc  = r_cnt + 8'd1;
  assign o_step_key = r_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_key   <= 8'd0;
      r_step  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_key   <= w_key_next;
      r_step  <= w_step_next;
    end
  end

  always_comb begin
    // Between ticks everything, including the output, simply holds.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_key_next   = r_key;
    w_step_next  = r_step;

    if (i_frame_tick) begin
      w_step_next = 8'd0;
      case (r_state)
        IDLE: begin
          if (i_held_key != 8'd0) begin
            w_step_next  = i_held_key;
            w_cnt_next   = 8'd0;
            w_key_next   = i_held_key;
            w_state_next = DELAY;
          end
        end

        DELAY, REPEAT: begin
          if (i_held_key == 8'd0) begin
            w_state_next = IDLE;
          end else if (i_held_key != r_key) begin
            // A different direction restarts the press sequence immediately.
            w_step_next  = i_held_key;
            w_cnt_next   = 8'd0;
            w_key_next   = i_held_key;
            w_state_next = DELAY;
          end else if (w_cnt_inc == ((r_state == DELAY) ? C_DELAY : C_RATE)) begin
            w_step_next  = r_key;
            w_cnt_next   = 8'd0;
            w_state_next = REPEAT;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end

        default: begin
          w_state_next = IDLE;
          w_cnt_next   = 8'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/keycode_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : keycode_dispatcher
//  Purpose  : Latches the six-slot HID keyboard report, ages it out after
//             STALE_FRAMES frames without an update, picks each player's
//             movement key by slot priority and converts it to per-frame step
//             keycodes through one key_repeater per player.
//  Ports    : Clk         - system clock
//             ResetN      - asynchronous active-low reset
//             KeyReport   - six keycodes, slot 0 = [7:0] .. slot 5 = [47:40]
//             ReportValid - one-cycle pulse, KeyReport is new this cycle
//             FrameTick   - one-cycle pulse per video frame
//             P1Keycode   - player one step keycode (held for one frame)
//             P2Keycode   - player two step keycode (held for one frame)
//             P1Held      - a player one movement key is held
//             P2Held      - a player two movement key is held
//  Revision : 1.0 - initial release
// ============================================================================
module keycode_dispatcher
  import crossy_keys_pkg::*;
#(
  parameter int REPEAT_DELAY = 12,
  parameter int REPEAT_RATE  = 6,
  parameter int STALE_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [47:0] KeyReport,
  input  logic        ReportValid,
  input  logic        FrameTick,
  output logic [7:0]  P1Keycode,
  output logic [7:0]  P2Keycode,
  output logic        P1Held,
  output logic        P2Held
);

  localparam logic [7:0] C_STALE      = 8'(STALE_FRAMES);
  localparam logic [7:0] C_STALE_LAST = 8'(STALE_FRAMES - 1);

  logic [47:0] r_report;
  logic [7:0]  r_stale_cnt;
  logic        r_p1_held;
  logic        r_p2_held;

  logic        w_tick_no_report;
  logic        w_stale;
  logic [47:0] w_report_eff;
  logic [7:0]  w_p1_key;
  logic [7:0]  w_p2_key;

  // --------------------------------------------------------------------------
  // Report latch and stale counter
  // --------------------------------------------------------------------------
  assign w_tick_no_report = FrameTick && !ReportValid;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_report    <= 48'd0;
      r_stale_cnt <= 8'd0;
    end else begin
      if (ReportValid) begin
        r_report    <= KeyReport;
        r_stale_cnt <= 8'd0;
      end else if (FrameTick && (r_stale_cnt != C_STALE)) begin
        r_stale_cnt <= r_stale_cnt + 8'd1;
      end
    end
  end

  // The tick that saturates the counter already counts as stale, so the
  // STALE_FRAMES-th report-less tick is the first one that sees no keys.
  assign w_stale = !ReportValid &&
                   ((r_stale_cnt == C_STALE) ||
                    (w_tick_no_report && (r_stale_cnt == C_STALE_LAST)));

  // A report arriving in the same cycle as the tick is used for that tick.
  assign w_report_eff = ReportValid ? KeyReport :
                        w_stale     ? 48'd0     : r_report;

  // --------------------------------------------------------------------------
  // Slot-priority decode: scanning from the top slot down lets the
  // lowest-numbered matching slot overwrite the others.
  // --------------------------------------------------------------------------
  always_comb begin
    w_p1_key = 8'd0;
    w_p2_key = 8'd0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (is_p1_key(w_report_eff[s*SLOT_W +: SLOT_W])) begin
        w_p1_key = w_report_eff[s*SLOT_W +: SLOT_W];
      end
      if (is_p2_key(w_report_eff[s*SLOT_W +: SLOT_W])) begin
        w_p2_key = w_report_eff[s*SLOT_W +: SLOT_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Held flags, sampled with the frame tick like the step keycodes
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_p1_held <= 1'b0;
      r_p2_held <= 1'b0;
    end else if (FrameTick) begin
      r_p1_held <= (w_p1_key != 8'd0);
      r_p2_held <= (w_p2_key != 8'd0);
    end
  end

  assign P1Held = r_p1_held;
  assign P2Held = r_p2_held;

  // --------------------------------------------------------------------------
  // Per-player repeat engines
  // --------------------------------------------------------------------------
  key_repeater #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep_p1 (
    .clk          (Clk),
    .rst_n        (ResetN),
    .i_frame_tick (FrameTick),
    .i_held_key   (w_p1_key),
    .o_step_key   (P1Keycode)
  );

  key_repeater #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep_p2 (
    .clk          (Clk),
    .rst_n        (ResetN),
    .i_frame_tick (FrameTick),
    .i_held_key   (w_p2_key),
    .o_step_key   (P2Keycode)
  );

endmodule
`default_nettype wire

// File: tb/tb_keycode_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keycode_dispatcher
//  Purpose  : Directed self-checking bench for keycode_dispatcher.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keycode_dispatcher;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [47:0] KeyReport = 48'd0;
  logic        ReportValid = 1'b0;
  logic        FrameTick = 1'b0;
  logic [7:0]  P1Keycode;
  logic [7:0]  P2Keycode;
  logic        P1Held;
  logic        P2Held;

  int checks = 0;
  int failures = 0;

  keycode_dispatcher #(
    .REPEAT_DELAY (12),
    .REPEAT_RATE  (6),
    .STALE_FRAMES (60)
  ) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .KeyReport   (KeyReport),
    .ReportValid (ReportValid),
    .FrameTick   (FrameTick),
    .P1Keycode   (P1Keycode),
    .P2Keycode   (P2Keycode),
    .P1Held      (P1Held),
    .P2Held      (P2Held)
  );

  always #5 Clk = ~Clk;

  // One frame: tick (optionally with a coincident report), then a few idle
  // cycles so outputs are sampled well after they settle and must be held.
  task automatic do_tick(input logic rv, input logic [47:0] rep);
    @(negedge Clk);
    FrameTick = 1'b1;
    ReportValid = rv;
    if (rv) KeyReport = rep;
    @(negedge Clk);
    FrameTick = 1'b0;
    ReportValid = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic send_report(input logic [47:0] rep);
    @(negedge Clk);
    ReportValid = 1'b1;
    KeyReport = rep;
    @(negedge Clk);
    ReportValid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clk);
    checks++;
    if (P1Keycode !== 8'h00 || P2Keycode !== 8'h00 || P1Held !== 1'b0 || P2Held !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: P1=%h P2=%h H1=%b H2=%b required 00 00 0 0", P1Keycode, P2Keycode, P1Held, P2Held);
    end
    ResetN = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_hold_w;
    logic [7:0] exp;
    do_tick(1'b1, 48'd0);
    for (int f = 0; f < 30; f++) begin
      do_tick(1'b1, {40'd0, 8'h1A});
      exp = (f == 0 || f == 12 || f == 18 || f == 24) ? 8'h1A : 8'h00;
      checks++;
      if (P1Keycode !== exp) begin
        failures++;
        $display("FAIL hold_w_p1 frame %0d: got %h required %h", f, P1Keycode, exp);
      end
      checks++;
      if (P2Keycode !== 8'h00 || P1Held !== 1'b1 || P2Held !== 1'b0) begin
        failures++;
        $display("FAIL hold_w_side frame %0d: P2=%h H1=%b H2=%b required 00 1 0", f, P2Keycode, P1Held, P2Held);
      end
    end
  endtask

  task automatic test_simultaneous;
    do_tick(1'b1, 48'd0);
    do_tick(1'b1, {32'd0, 8'h50, 8'h04});
    checks++;
    if (P1Keycode !== 8'h04 || P2Keycode !== 8'h50 || P1Held !== 1'b1 || P2Held !== 1'b1) begin
      failures++;
      $display("FAIL both_players: P1=%h P2=%h H1=%b H2=%b required 04 50 1 1", P1Keycode, P2Keycode, P1Held, P2Held);
    end
    do_tick(1'b1, 48'd0);
    do_tick(1'b1, {32'd0, 8'h04, 8'h1A});
    checks++;
    if (P1Keycode !== 8'h1A || P2Keycode !== 8'h00) begin
      failures++;
      $display("FAIL slot_priority: P1=%h P2=%h required 1A 00", P1Keycode, P2Keycode);
    end
    do_tick(1'b1, 48'd0);
    // Non-movement key in slot 0 and P2 keys spread over higher slots
    do_tick(1'b1, {16'd0, 8'h1A, 8'h4F, 8'h07, 8'h29});
    checks++;
    if (P1Keycode !== 8'h07 || P2Keycode !== 8'h4F) begin
      failures++;
      $display("FAIL ignore_other_keys: P1=%h P2=%h required 07 4F", P1Keycode, P2Keycode);
    end
    do_tick(1'b1, 48'd0);
    checks++;
    if (P1Keycode !== 8'h00 || P2Keycode !== 8'h00 || P1Held !== 1'b0 || P2Held !== 1'b0) begin
      failures++;
      $display("FAIL release_all: P1=%h P2=%h H1=%b H2=%b required 00 00 0 0", P1Keycode, P2Keycode, P1Held, P2Held);
    end
  endtask

  task automatic test_direction_change;
    logic [7:0] exp;
    do_tick(1'b1, 48'd0);
    for (int f = 0; f < 18; f++) begin
      if (f < 5) begin
        do_tick(1'b1, {40'd0, 8'h07});
        exp = (f == 0) ? 8'h07 : 8'h00;
      end else begin
        do_tick(1'b1, {40'd0, 8'h16});
        exp = (f == 5 || f == 17) ? 8'h16 : 8'h00;
      end
      checks++;
      if (P1Keycode !== exp) begin
        failures++;
        $display("FAIL direction_change frame %0d: got %h required %h", f, P1Keycode, exp);
      end
    end
  endtask

  task automatic test_stale;
    logic [7:0] exp;
    logic       exp_held;
    do_tick(1'b1, 48'd0);
    send_report({40'd0, 8'h1A});
    for (int t = 1; t <= 62; t++) begin
      do_tick(1'b0, 48'd0);
      exp = ((t == 1) || (t >= 13 && t < 60 && ((t - 13) % 6) == 0)) ? 8'h1A : 8'h00;
      exp_held = (t < 60);
      checks++;
      if (P1Keycode !== exp || P1Held !== exp_held) begin
        failures++;
        $display("FAIL stale tick %0d: P1=%h H1=%b required %h %b", t, P1Keycode, P1Held, exp, exp_held);
      end
    end
  endtask

  task automatic test_same_cycle;
    do_tick(1'b1, 48'd0);
    do_tick(1'b1, {40'd0, 8'h1A});
    checks++;
    if (P1Keycode !== 8'h1A) begin
      failures++;
      $display("FAIL same_cycle_press: got %h required 1A", P1Keycode);
    end
    do_tick(1'b1, {40'd0, 8'h1A});
    do_tick(1'b1, 48'd0);
    checks++;
    if (P1Keycode !== 8'h00 || P1Held !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_release: P1=%h H1=%b required 00 0", P1Keycode, P1Held);
    end
    do_tick(1'b1, {40'd0, 8'h1A});
    checks++;
    if (P1Keycode !== 8'h1A) begin
      failures++;
      $display("FAIL same_cycle_repress: got %h required 1A", P1Keycode);
    end
  endtask

  task automatic test_mid_reset;
    do_tick(1'b1, 48'd0);
    do_tick(1'b1, {32'd0, 8'h4F, 8'h1A});
    checks++;
    if (P1Keycode !== 8'h1A || P2Keycode !== 8'h4F || P1Held !== 1'b1 || P2Held !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: P1=%h P2=%h H1=%b H2=%b required 1A 4F 1 1", P1Keycode, P2Keycode, P1Held, P2Held);
    end
    @(negedge Clk);
    #2 ResetN = 1'b0;
    #1;
    checks++;
    if (P1Keycode !== 8'h00 || P2Keycode !== 8'h00 || P1Held !== 1'b0 || P2Held !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: P1=%h P2=%h H1=%b H2=%b required 00 00 0 0", P1Keycode, P2Keycode, P1Held, P2Held);
    end
    @(negedge Clk);
    ResetN = 1'b1;
    // Latched report must have been cleared by reset
    do_tick(1'b0, 48'd0);
    checks++;
    if (P1Keycode !== 8'h00 || P1Held !== 1'b0 || P2Held !== 1'b0) begin
      failures++;
      $display("FAIL report_cleared: P1=%h H1=%b H2=%b required 00 0 0", P1Keycode, P1Held, P2Held);
    end
    do_tick(1'b1, {32'd0, 8'h4F, 8'h1A});
    checks++;
    if (P1Keycode !== 8'h1A || P2Keycode !== 8'h4F) begin
      failures++;
      $display("FAIL post_reset_press: P1=%h P2=%h required 1A 4F", P1Keycode, P2Keycode);
    end
  endtask

  initial begin
    test_reset;
    test_hold_w;
    test_simultaneous;
    test_direction_change;
    test_stale;
    test_same_cycle;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
